// File: rtl/sccb_arb_pkg.sv
// Shared types and defaults for the SCCB write-master arbiter.
package sccb_arb_pkg;

  localparam int unsigned MAX_REQ       = 4;
  localparam int unsigned IDX_W         = 2;
  localparam int unsigned DEF_MAX_RETRY = 3;
  localparam int unsigned DEF_GAP       = 8;
  localparam int unsigned DEF_TIMEOUT   = 2047;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GAP_WAIT,
    ST_RESP
  } state_e;

  function automatic logic [MAX_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [MAX_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/sccb_rr_pick.sv
// Round-robin picker: first eligible index strictly after ptr_i, wrapping.
module sccb_rr_pick
  import sccb_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic [N_REQ-1:0] elig_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [2:0]       sh;
  logic [N_REQ-1:0] rot;
  logic [2:0]       sum;

  // rot[j] is the requester sitting j+1 places after the pointer
  assign sh  = 3'(ptr_i) + 3'd1;
  assign rot = N_REQ'({elig_i, elig_i} >> sh);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    for (int j = 0; j < int'(N_REQ); j++) begin
      if (rot[j] && !valid_o) begin
        valid_o = 1'b1;
        sum     = sh + 3'(j);
        if (sum >= 3'(N_REQ)) begin
          sum = sum - 3'(N_REQ);
        end
        idx_o = IDX_W'(sum);
      end
    end
  end

endmodule

// File: rtl/sccb_arbiter.sv
// Arbitrates N_REQ register-write requesters onto one OV7670 SCCB write master,
// with exclusive init mode, NACK retry after a gap and per-phase timeouts.
module sccb_arbiter
  import sccb_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned MAX_RETRY = DEF_MAX_RETRY,
  parameter int unsigned GAP       = DEF_GAP,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic               clk_800KHz,
  input  logic               rst_n,
  input  logic               excl,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   err,
  output logic [7:0]         sccb_addr,
  output logic [7:0]         sccb_data,
  output logic               sccb_en,
  input  logic               sccb_ready,
  input  logic               sccb_busy,
  input  logic               sccb_ack,
  output logic               arb_busy
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         retry_q, retry_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [N_REQ-1:0]   err_q, err_d;
  logic [7:0]         addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;

  logic [N_REQ-1:0]   elig;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               launch, timer_to, gap_end, xfer_end, retry_ok;
  logic               finish, fail;
  logic [N_REQ-1:0]   owner_oh;

  // Exclusive mode masks every requester except the init sequencer
  assign elig     = excl ? (req & N_REQ'(1)) : req;
  assign launch   = pick_valid & sccb_ready;
  assign timer_to = (timer_q == TW'(TIMEOUT));
  assign gap_end  = (timer_q == TW'(GAP - 1));
  assign xfer_end = ~sccb_busy & sccb_ready;
  assign retry_ok = (retry_q < 2'(MAX_RETRY));
  assign owner_oh = N_REQ'(idx_onehot(idx_q));

  sccb_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk_800KHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      timer_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      timer_q <= timer_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (launch) state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (sccb_busy)     state_d = ST_WAIT_DONE;
        else if (timer_to) state_d = ST_RESP;
      end
      ST_WAIT_DONE: begin
        if (xfer_end)      state_d = (!sccb_ack && retry_ok) ? ST_GAP_WAIT : ST_RESP;
        else if (timer_to) state_d = ST_RESP;
      end
      ST_GAP_WAIT: begin
        if (gap_end) state_d = ST_WAIT_BUSY;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    timer_d = timer_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    en_d    = en_q;
    finish  = 1'b0;
    fail    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (launch) begin
          gnt_d   = N_REQ'(idx_onehot(pick_idx));
          ptr_d   = pick_idx;
          idx_d   = pick_idx;
          retry_d = '0;
          timer_d = '0;
          en_d    = 1'b1;
          for (int i = 0; i < int'(N_REQ); i++) begin
            if (pick_idx == IDX_W'(i)) begin
              addr_d = req_addr[8*i +: 8];
              data_d = req_data[8*i +: 8];
            end
          end
        end
      end
      ST_WAIT_BUSY: begin
        if (sccb_busy) begin
          en_d    = 1'b0;
          timer_d = '0;
        end else if (timer_to) begin
          finish = 1'b1;
          fail   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (xfer_end) begin
          if (sccb_ack) begin
            finish = 1'b1;
          end else if (retry_ok) begin
            retry_d = retry_q + 2'd1;
            timer_d = '0;
          end else begin
            finish = 1'b1;
            fail   = 1'b1;
          end
        end else if (timer_to) begin
          finish = 1'b1;
          fail   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_GAP_WAIT: begin
        // Timer doubles as the gap counter; retry reuses the latched operands
        if (gap_end) begin
          en_d    = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: ;
    endcase

    if (finish) begin
      done_d = owner_oh;
      err_d  = fail ? owner_oh : '0;
      gnt_d  = '0;
      en_d   = 1'b0;
    end
  end

  assign busy_d    = (state_d != ST_IDLE);

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign sccb_addr = addr_q;
  assign sccb_data = data_q;
  assign sccb_en   = en_q;
  assign arb_busy  = busy_q;

endmodule

// File: tb/tb_sccb_arbiter.sv
// Directed self-checking bench for sccb_arbiter with a small behavioural SCCB master.
`timescale 1ns/1ps
module tb_sccb_arbiter;

  localparam int TIMEOUT = 2047;
  localparam int GAP     = 8;

  logic        clk_800KHz = 1'b0;
  logic        rst_n      = 1'b0;
  logic        excl       = 1'b0;
  logic [1:0]  req        = '0;
  logic [15:0] req_addr   = '0;
  logic [15:0] req_data   = '0;
  logic [1:0]  gnt, done, err;
  logic [7:0]  sccb_addr, sccb_data;
  logic        sccb_en, arb_busy;
  logic        sccb_ready, sccb_busy, sccb_ack;

  int errors = 0;
  int checks = 0;

  // master model controls and observations
  int m_lat  = 4;
  int m_nack = 0;
  bit m_dead = 1'b0;
  int attempts = 0;
  int cyc = 0;
  int start_cyc [64];
  int mst = 0;
  int mcnt = 0;

  always #5 clk_800KHz = ~clk_800KHz;

  sccb_arbiter #(.N_REQ(2), .MAX_RETRY(3), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk_800KHz (clk_800KHz),
    .rst_n      (rst_n),
    .excl       (excl),
    .req        (req),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .gnt        (gnt),
    .done       (done),
    .err        (err),
    .sccb_addr  (sccb_addr),
    .sccb_data  (sccb_data),
    .sccb_en    (sccb_en),
    .sccb_ready (sccb_ready),
    .sccb_busy  (sccb_busy),
    .sccb_ack   (sccb_ack),
    .arb_busy   (arb_busy)
  );

  // Behavioural master: start on en, busy for m_lat cycles, then ready with ack
  initial begin
    sccb_ready = 1'b1;
    sccb_busy  = 1'b0;
    sccb_ack   = 1'b0;
    forever begin
      @(posedge clk_800KHz);
      cyc++;
      #1;
      if (!rst_n) begin
        mst = 0;
        sccb_busy  = 1'b0;
        sccb_ready = 1'b1;
        sccb_ack   = 1'b0;
      end else if (mst == 0) begin
        if (sccb_en && !m_dead) begin
          sccb_busy  = 1'b1;
          sccb_ready = 1'b0;
          mcnt = 0;
          mst  = 1;
          if (attempts < 64) start_cyc[attempts] = cyc;
          attempts++;
        end
      end else begin
        mcnt++;
        if (mcnt >= m_lat) begin
          sccb_busy  = 1'b0;
          sccb_ready = 1'b1;
          sccb_ack   = (m_nack == 0);
          if (m_nack > 0) m_nack--;
          mst = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_800KHz);
    #1;
  endtask

  task automatic wait_gnt(input int budget, output logic [1:0] g, output int n);
    n = 0;
    g = '0;
    while (n < budget && g == 2'b00) begin
      tick();
      n++;
      g = gnt;
    end
  endtask

  task automatic wait_done(input int budget, output logic [1:0] d, output logic [1:0] e, output int n);
    n = 0;
    d = '0;
    e = '0;
    while (n < budget && d == 2'b00) begin
      tick();
      n++;
      d = done;
      e = err;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({gnt, done, err, sccb_en, arb_busy} !== 8'h00) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000000", {gnt, done, err, sccb_en, arb_busy});
    end
    checks++;
    if ({sccb_addr, sccb_data} !== 16'h0000) begin
      errors++; $display("FAIL reset_operands: got %h want 0000", {sccb_addr, sccb_data});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({gnt, arb_busy} !== 3'b000) begin
      errors++; $display("FAIL reset_idle: got %b want 000", {gnt, arb_busy});
    end
  endtask

  task automatic test_single();
    logic [1:0] g, d, e;
    int n;
    m_lat = 40; m_nack = 0;
    req_addr = 16'h0012; req_data = 16'h0080; req = 2'b01;
    wait_gnt(10, g, n);
    checks++;
    if (n !== 1 || g !== 2'b01) begin
      errors++; $display("FAIL single_gnt: got gnt=%b after %0d want 01 after 1", g, n);
    end
    checks++;
    if ({sccb_en, arb_busy, sccb_addr, sccb_data} !== {2'b11, 16'h1280}) begin
      errors++; $display("FAIL single_launch: got en=%b busy=%b addr=%h data=%h want 1 1 12 80",
                         sccb_en, arb_busy, sccb_addr, sccb_data);
    end
    tick();
    checks++;
    if (sccb_en !== 1'b0 || gnt !== 2'b01) begin
      errors++; $display("FAIL single_en_fall: got en=%b gnt=%b want 0 01", sccb_en, gnt);
    end
    wait_done(100, d, e, n);
    checks++;
    if (n !== 40 || d !== 2'b01 || e !== 2'b00 || gnt !== 2'b00) begin
      errors++; $display("FAIL single_done: got n=%0d done=%b err=%b gnt=%b want 40 01 00 00", n, d, e, gnt);
    end
    req = 2'b00;
    tick();
    checks++;
    if (done !== 2'b00 || arb_busy !== 1'b0) begin
      errors++; $display("FAIL single_pulse: got done=%b busy=%b want 00 0", done, arb_busy);
    end
  endtask

  task automatic test_excl();
    logic [1:0] g, d, e;
    int n;
    m_lat = 4;
    excl = 1'b1;
    req_addr = 16'h3020; req_data = 16'h0201; req = 2'b11;
    wait_gnt(10, g, n);
    checks++;
    if (g !== 2'b01 || sccb_addr !== 8'h20 || sccb_data !== 8'h01) begin
      errors++; $display("FAIL excl_first: got gnt=%b addr=%h data=%h want 01 20 01", g, sccb_addr, sccb_data);
    end
    wait_done(50, d, e, n);
    checks++;
    if (n !== 5 || d !== 2'b01 || e !== 2'b00) begin
      errors++; $display("FAIL excl_done1: got n=%0d done=%b err=%b want 5 01 00", n, d, e);
    end
    wait_gnt(10, g, n);
    checks++;
    if (n !== 2 || g !== 2'b01) begin
      errors++; $display("FAIL excl_regrant: got gnt=%b after %0d want 01 after 2", g, n);
    end
    excl = 1'b0;
    wait_done(50, d, e, n);
    checks++;
    if (d !== 2'b01 || e !== 2'b00) begin
      errors++; $display("FAIL excl_mid_change: got done=%b err=%b want 01 00", d, e);
    end
    wait_gnt(10, g, n);
    checks++;
    if (n !== 2 || g !== 2'b10 || sccb_addr !== 8'h30 || sccb_data !== 8'h02) begin
      errors++; $display("FAIL excl_release: got gnt=%b n=%0d addr=%h data=%h want 10 2 30 02",
                         g, n, sccb_addr, sccb_data);
    end
    wait_done(50, d, e, n);
    checks++;
    if (d !== 2'b10 || e !== 2'b00) begin
      errors++; $display("FAIL excl_done_r1: got done=%b err=%b want 10 00", d, e);
    end
    req = 2'b00;
  endtask

  task automatic test_rr();
    logic [1:0] g, d, e;
    logic [1:0] want;
    logic [7:0] want_addr;
    int n;
    want = 2'b01;
    req_addr = 16'h5040; req_data = 16'h5141; req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      want_addr = (want == 2'b01) ? 8'h40 : 8'h50;
      wait_gnt(10, g, n);
      checks++;
      if (n !== 2 || g !== want || sccb_addr !== want_addr) begin
        errors++; $display("FAIL rr_gnt%0d: got gnt=%b n=%0d addr=%h want %b 2 %h", k, g, n, sccb_addr, want, want_addr);
      end
      wait_done(50, d, e, n);
      checks++;
      if (d !== want || e !== 2'b00) begin
        errors++; $display("FAIL rr_done%0d: got done=%b err=%b want %b 00", k, d, e, want);
      end
      want = ~want;
    end
    req = 2'b00;
  endtask

  task automatic test_nack_ack();
    logic [1:0] g, d, e;
    int n, a0;
    m_lat = 4; m_nack = 1;
    a0 = attempts;
    req_addr = 16'h0055; req_data = 16'h00AA; req = 2'b01;
    wait_gnt(10, g, n);
    req_addr = 16'h0099;
    wait_done(100, d, e, n);
    checks++;
    if (n !== 18 || d !== 2'b01 || e !== 2'b00) begin
      errors++; $display("FAIL nack_ack_done: got n=%0d done=%b err=%b want 18 01 00", n, d, e);
    end
    checks++;
    if (attempts - a0 !== 2 || start_cyc[a0+1] - start_cyc[a0] !== 4 + 1 + GAP) begin
      errors++; $display("FAIL nack_ack_attempts: got %0d attempts spacing %0d want 2 spacing %0d",
                         attempts - a0, start_cyc[a0+1] - start_cyc[a0], 4 + 1 + GAP);
    end
    checks++;
    if (sccb_addr !== 8'h55 || sccb_data !== 8'hAA) begin
      errors++; $display("FAIL nack_ack_latched: got addr=%h data=%h want 55 AA", sccb_addr, sccb_data);
    end
    req = 2'b00;
  endtask

  task automatic test_nack_fail();
    logic [1:0] g, d, e;
    int n, a0;
    m_lat = 4; m_nack = 100;
    a0 = attempts;
    req_addr = 16'h003A; req_data = 16'h0004; req = 2'b01;
    wait_gnt(10, g, n);
    wait_done(200, d, e, n);
    checks++;
    if (n !== 44 || d !== 2'b01 || e !== 2'b01) begin
      errors++; $display("FAIL nack_fail_done: got n=%0d done=%b err=%b want 44 01 01", n, d, e);
    end
    checks++;
    if (attempts - a0 !== 4) begin
      errors++; $display("FAIL nack_fail_attempts: got %0d want 4", attempts - a0);
    end
    req = 2'b00;
    m_nack = 0;
  endtask

  task automatic test_timeout();
    logic [1:0] g, d, e;
    int n;
    m_dead = 1'b1;
    req_addr = 16'h0013; req_data = 16'h00E7; req = 2'b01;
    wait_gnt(10, g, n);
    repeat (100) tick();
    checks++;
    if (sccb_en !== 1'b1 || arb_busy !== 1'b1 || done !== 2'b00) begin
      errors++; $display("FAIL timeout_hold: got en=%b busy=%b done=%b want 1 1 00", sccb_en, arb_busy, done);
    end
    wait_done(3000, d, e, n);
    checks++;
    if (n + 100 !== TIMEOUT + 1 || d !== 2'b01 || e !== 2'b01 || sccb_en !== 1'b0) begin
      errors++; $display("FAIL timeout_done: got n=%0d done=%b err=%b en=%b want %0d 01 01 0",
                         n + 100, d, e, sccb_en, TIMEOUT + 1);
    end
    req = 2'b00;
    m_dead = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [1:0] g, d, e;
    int n;
    m_lat = 40;
    req_addr = 16'h0011; req_data = 16'h0022; req = 2'b01;
    wait_gnt(10, g, n);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, done, err, sccb_en, arb_busy, sccb_addr, sccb_data} !== 24'h0) begin
      errors++; $display("FAIL reset_mid_outputs: got %h want 000000",
                         {gnt, done, err, sccb_en, arb_busy, sccb_addr, sccb_data});
    end
    tick();
    tick();
    rst_n = 1'b1;
    wait_gnt(10, g, n);
    checks++;
    if (n !== 1 || g !== 2'b01 || sccb_addr !== 8'h11) begin
      errors++; $display("FAIL reset_mid_regrant: got gnt=%b n=%0d addr=%h want 01 1 11", g, n, sccb_addr);
    end
    wait_done(100, d, e, n);
    checks++;
    if (n !== 41 || d !== 2'b01 || e !== 2'b00) begin
      errors++; $display("FAIL reset_mid_done: got n=%0d done=%b err=%b want 41 01 00", n, d, e);
    end
    req = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_excl();
    test_rr();
    test_nack_ack();
    test_nack_fail();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
